// File: rtl/mem_port_sched.sv
// mem_port_sched: write/read request scheduler and response FIFO
// in front of a dual-address word memory with half-swapped upper bank.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   wr_valid/wr_ready         write request handshake (wr_addr, wr_data)
//   rd_valid/rd_ready         read request handshake (rd_addr)
//   rsp_valid/rsp_ready       read response handshake (rsp_data, rsp_addr)
//   mem_wr, mem_wr_addr/data  memory write strobe and operands
//   mem_rd, mem_rd_addr       memory read strobe and address
//   mem_rd_data               memory registered read output
module mem_port_sched #(
  parameter int WIDTH     = 256,
  parameter int PSIZE     = 5,
  parameter int RSP_DEPTH = 4,
  parameter int UNSWAP    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [PSIZE-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [PSIZE-1:0] rd_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [PSIZE-1:0] rsp_addr,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic [PSIZE-1:0] mem_wr_addr,
  output logic [PSIZE-1:0] mem_rd_addr,
  output logic [WIDTH-1:0] mem_wr_data,
  input  logic [WIDTH-1:0] mem_rd_data
);

  localparam int AW = $clog2(RSP_DEPTH);
  localparam int HW = WIDTH / 2;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(RSP_DEPTH);

  logic [AW:0]       wptr, rptr;
  logic [AW:0]       occ, inflight, credits;
  logic              full, empty;
  logic              prio;
  logic              tag1;
  logic [PSIZE-1:0]  addr1;
  logic              wr_elig, rd_elig;
  logic              wr_acc, rd_acc;
  logic              push, pop, swap;
  logic [WIDTH-1:0]  push_data;
  logic [WIDTH-1:0]  fifo_d [RSP_DEPTH];
  logic [PSIZE-1:0]  fifo_a [RSP_DEPTH];

  // Credits reserve a FIFO slot for every read still in the pipe.
  assign occ      = wptr - rptr;
  assign inflight = {{AW{1'b0}}, mem_rd}
                  + {{AW{1'b0}}, tag1};
  assign credits  = DEPTH_C - occ - inflight;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW])
              && (wptr[AW-1:0] == rptr[AW-1:0]);

  // prio: 0 = write side wins a tie, 1 = read side.
  assign wr_elig  = wr_valid;
  assign rd_elig  = rd_valid && (credits != '0);
  assign wr_ready = wr_elig && (!prio || !rd_elig);
  assign rd_ready = rd_elig && (prio || !wr_elig);
  assign wr_acc   = wr_valid && wr_ready;
  assign rd_acc   = rd_valid && rd_ready;

  assign push = tag1;
  assign pop  = rsp_valid && rsp_ready;
  assign swap = (UNSWAP != 0) && addr1[PSIZE-1];

  always_comb begin
    push_data = mem_rd_data;
    unique case (1'b1)
      swap:    push_data = {mem_rd_data[HW-1:0],
                            mem_rd_data[WIDTH-1:HW]};
      default: push_data = mem_rd_data;
    endcase
  end

  assign rsp_valid = !empty;
  assign rsp_data  = fifo_d[rptr[AW-1:0]];
  assign rsp_addr  = fifo_a[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr_addr <= '0;
      mem_rd_addr <= '0;
      mem_wr_data <= '0;
      tag1        <= 1'b0;
      addr1       <= '0;
      prio        <= 1'b0;
    end else begin
      mem_wr <= wr_acc;
      mem_rd <= rd_acc;
      if (wr_acc) begin
        mem_wr_addr <= wr_addr;
        mem_wr_data <= wr_data;
      end
      if (rd_acc) mem_rd_addr <= rd_addr;
      // Memory output is valid the cycle after mem_rd.
      tag1  <= mem_rd;
      addr1 <= mem_rd_addr;
      if (wr_elig && rd_elig) prio <= ~prio;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_d[i] <= '0;
        fifo_a[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_d[wptr[AW-1:0]] <= push_data;
        fifo_a[wptr[AW-1:0]] <= addr1;
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst) !(push && full));

  a_one_strobe: assert property (
    @(posedge clk) disable iff (rst) !(mem_wr && mem_rd));

endmodule

// File: tb/tb_mem_port_sched.sv
// tb_mem_port_sched: directed bench for mem_port_sched,
// two instances (UNSWAP=1 and UNSWAP=0) on shared stimulus.
module tb_mem_port_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_valid = 1'b0;
  logic [4:0]   wr_addr = '0;
  logic [255:0] wr_data = '0;
  logic         rd_valid = 1'b0;
  logic [4:0]   rd_addr = '0;
  logic         rsp_ready = 1'b0;

  logic         wr_ready1, rd_ready1, rsp_valid1;
  logic [255:0] rsp_data1, mem_wr_data1;
  logic [4:0]   rsp_addr1, mem_wr_addr1, mem_rd_addr1;
  logic         mem_wr1, mem_rd1;
  logic [255:0] mem_rd_data1 = '0;

  logic         wr_ready0, rd_ready0, rsp_valid0;
  logic [255:0] rsp_data0, mem_wr_data0;
  logic [4:0]   rsp_addr0, mem_wr_addr0, mem_rd_addr0;
  logic         mem_wr0, mem_rd0;
  logic [255:0] mem_rd_data0 = '0;

  logic [255:0] m1 [32];
  logic [255:0] m0 [32];

  int checks = 0;
  int failures = 0;
  int both_seen = 0;

  always #5 clk = ~clk;

  mem_port_sched #(.UNSWAP(1)) dut1 (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready1),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready1),
    .rd_addr(rd_addr),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data1), .rsp_addr(rsp_addr1),
    .mem_wr(mem_wr1), .mem_rd(mem_rd1),
    .mem_wr_addr(mem_wr_addr1),
    .mem_rd_addr(mem_rd_addr1),
    .mem_wr_data(mem_wr_data1),
    .mem_rd_data(mem_rd_data1)
  );

  mem_port_sched #(.UNSWAP(0)) dut0 (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready0),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready0),
    .rd_addr(rd_addr),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data0), .rsp_addr(rsp_addr0),
    .mem_wr(mem_wr0), .mem_rd(mem_rd0),
    .mem_wr_addr(mem_wr_addr0),
    .mem_rd_addr(mem_rd_addr0),
    .mem_wr_data(mem_wr_data0),
    .mem_rd_data(mem_rd_data0)
  );

  function automatic logic [255:0] sw(
    input logic [255:0] d);
    return {d[127:0], d[255:128]};
  endfunction

  function automatic logic [255:0] dat(input int i);
    return {128'(i + 128), 128'(i)};
  endfunction

  // Memory model: upper address half stores halves swapped.
  always @(posedge clk) begin
    if (mem_wr1)
      m1[mem_wr_addr1] <= mem_wr_addr1[4]
        ? sw(mem_wr_data1) : mem_wr_data1;
    if (mem_rd1) mem_rd_data1 <= m1[mem_rd_addr1];
    if (mem_wr0)
      m0[mem_wr_addr0] <= mem_wr_addr0[4]
        ? sw(mem_wr_data0) : mem_wr_data0;
    if (mem_rd0) mem_rd_data0 <= m0[mem_rd_addr0];
  end

  always @(negedge clk)
    if ((mem_wr1 && mem_rd1) || (mem_wr0 && mem_rd0))
      both_seen++;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic wr_then_rd(input logic [4:0] a,
                            input logic [255:0] d,
                            input logic [255:0] e1,
                            input logic [255:0] e0);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    #1 chk("wr_ready", wr_ready1, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("wr_strobe", mem_wr1, 1);
    chk("wr_addr", mem_wr_addr1, a);
    chk("wr_data", mem_wr_data1, d);
    rd_valid = 1'b1; rd_addr = a;
    #1 chk("rd_ready", rd_ready1, 1);
    @(negedge clk);
    rd_valid = 1'b0;
    chk("wr_drop", mem_wr1, 0);
    chk("rd_strobe", mem_rd1, 1);
    chk("rd_addr", mem_rd_addr1, a);
    @(negedge clk);
    chk("rsp_early", rsp_valid1, 0);
    @(negedge clk);
    chk("rsp_valid", rsp_valid1, 1);
    chk("rsp_addr", rsp_addr1, a);
    chk("rsp_data_u1", rsp_data1, e1);
    chk("rsp_data_u0", rsp_data0, e0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_popped", rsp_valid1, 0);
  endtask

  logic [127:0] hh, ll;
  logic [255:0] aa;

  initial begin
    for (int i = 0; i < 32; i++) begin
      m1[i] = '0;
      m0[i] = '0;
    end
    hh = 128'h0123456789abcdef_fedcba9876543210;
    ll = 128'h1122334455667788_99aabbccddeeff00;
    aa = {64'hdeadbeef_00000003, 64'h5a5a5a5a_a5a5a5a5,
          64'h0f0f0f0f_f0f0f0f0, 64'h13579bdf_2468ace0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_wr", mem_wr1, 0);
    chk("rst_mem_rd", mem_rd1, 0);
    chk("rst_rsp_valid", rsp_valid1, 0);
    chk("rst_rsp_data", rsp_data1, 0);
    chk("rst_rsp_addr", rsp_addr1, 0);
    rst = 1'b0;
    @(negedge clk);

    // Write/read round trip, lower and upper half
    wr_then_rd(5'd3, aa, aa, aa);
    wr_then_rd(5'd20, {hh, ll}, {hh, ll}, {ll, hh});

    // Contention: grants alternate W,R,W,R...
    rsp_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd6; wr_data = aa;
    rd_valid = 1'b1; rd_addr = 5'd5;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("alt_wr_ready", wr_ready1, (i % 2) == 0);
      chk("alt_rd_ready", rd_ready1, (i % 2) == 1);
      @(negedge clk);
      chk("alt_mem_wr", mem_wr1, (i % 2) == 0);
      chk("alt_mem_rd", mem_rd1, (i % 2) == 1);
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("alt_drained", rsp_valid1, 0);

    // Credit limit with responses stalled
    rsp_ready = 1'b0;
    rd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rd_addr = 5'(8 + ((i < 4) ? i : 4));
      #1 chk("cred_rd_ready", rd_ready1, i < 4);
      @(negedge clk);
    end
    chk("cred_rsp_valid", rsp_valid1, 1);
    chk("cred_head", rsp_addr1, 8);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 chk("cred_return", rd_ready1, 1);
    chk("cred_head2", rsp_addr1, 9);
    @(negedge clk);
    #1 chk("cred_again0", rd_ready1, 0);
    rd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("order_valid", rsp_valid1, 1);
      chk("order_addr", rsp_addr1, 9 + k);
      @(negedge clk);
    end
    chk("order_empty", rsp_valid1, 0);

    // Fill all 32 words, then stream reads back
    wr_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wr_addr = 5'(i);
      wr_data = dat(i);
      #1 chk("fill_wr_ready", wr_ready1, 1);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 35; k++) begin
      rd_valid = (k < 32);
      rd_addr = 5'(k);
      #1;
      if (k < 32) chk("strm_rd_ready", rd_ready1, 1);
      if (k >= 3) begin
        chk("strm_valid", rsp_valid1, 1);
        chk("strm_addr", rsp_addr1, k - 3);
        chk("strm_data_u1", rsp_data1, dat(k - 3));
        chk("strm_data_u0", rsp_data0,
            (k - 3 >= 16) ? sw(dat(k - 3)) : dat(k - 3));
      end
      @(negedge clk);
    end
    rd_valid = 1'b0;
    chk("strm_empty", rsp_valid1, 0);

    // Reset with two reads in flight
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = 5'd1;
    @(negedge clk);
    rd_addr = 5'd2;
    @(negedge clk);
    rd_valid = 1'b0;
    chk("pre_rst_rd", mem_rd1, 1);
    rst = 1'b1;
    #1;
    chk("arst_mem_rd", mem_rd1, 0);
    chk("arst_mem_wr", mem_wr1, 0);
    chk("arst_rd_addr", mem_rd_addr1, 0);
    chk("arst_wr_addr", mem_wr_addr1, 0);
    chk("arst_wr_data", mem_wr_data1, 0);
    chk("arst_rsp_valid", rsp_valid1, 0);
    chk("arst_rsp_data", rsp_data1, 0);
    chk("arst_rsp_addr", rsp_addr1, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", rsp_valid1, 0);
    end
    rd_valid = 1'b1; rd_addr = 5'd7;
    for (int i = 0; i < 6; i++) begin
      #1 chk("post_rst_cred", rd_ready1, i < 4);
      @(negedge clk);
    end
    rd_valid = 1'b0;

    chk("never_both", both_seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
